// File: rtl/weight_load_ctrl.sv
// Weight-buffer load sequencer: streams NUM_WSET sets of NUM_RDATA words from weight memory into
// the kernel write ports and hands each full set to the PE array. Optional perf counter: WLC_PERF_CNT_EN.
module weight_load_ctrl #(
  parameter int DAT_WIDTH   = 8,
  parameter int NUM_KERNEL  = 4,
  parameter int NUM_CHANNEL = 3,
  parameter int NUM_RDATA   = 3,
  parameter int ADDR_WIDTH  = 16,
  parameter int SET_WIDTH   = 12
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_start,
  input  logic [ADDR_WIDTH-1:0]                       i_base_addr,
  input  logic [SET_WIDTH-1:0]                        i_num_wset,
  output logic                                        o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                       o_mem_addr,
  input  logic [DAT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] i_mem_data,
  input  logic                                        i_mem_val,
  output logic [DAT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] o_wb_data_kn,
  output logic                                        o_wb_val,
  input  logic                                        i_wb_full,
  output logic                                        o_wb_req,
  input  logic                                        i_pe_ready,
  output logic                                        o_busy,
  output logic                                        o_done,
  output logic [31:0]                                 o_stall_cnt
);

  localparam int WORD_W = DAT_WIDTH * NUM_CHANNEL * NUM_KERNEL;
  localparam int CNT_W  = $clog2(NUM_RDATA + 1);
  localparam logic [CNT_W-1:0] RDATA_LAST = CNT_W'(NUM_RDATA);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_FULL, ISSUE, DRAIN, DONE} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [SET_WIDTH-1:0]  set_cnt_reg, num_wset_reg;
  logic [CNT_W-1:0]      rd_cnt_reg, ret_cnt_reg;
  logic                  drain_cnt_reg;
  logic [WORD_W-1:0]     wb_data_reg;
  logic                  wb_val_reg, wb_req_reg;
  logic                  rd_fire, accept_val, start_job, last_set;

  assign start_job  = (state_reg == IDLE) && i_start;
  assign rd_fire    = (state_reg == LOAD) && (rd_cnt_reg != RDATA_LAST);
  // Returns arriving outside a load window are discarded silently.
  assign accept_val = i_mem_val && ((state_reg == LOAD) || (state_reg == WAIT_FULL));
  assign last_set   = (SET_WIDTH'(set_cnt_reg + 1'b1) == num_wset_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (i_start) state_next = (i_num_wset == '0) ? DONE : LOAD;
      LOAD:      if (ret_cnt_reg == RDATA_LAST) state_next = WAIT_FULL;
      WAIT_FULL: if (i_wb_full && !wb_val_reg) state_next = ISSUE;
      ISSUE:     if (i_pe_ready) state_next = DRAIN;
      DRAIN:     if (drain_cnt_reg) state_next = last_set ? DONE : LOAD;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      set_cnt_reg   <= '0;
      num_wset_reg  <= '0;
      rd_cnt_reg    <= '0;
      ret_cnt_reg   <= '0;
      drain_cnt_reg <= 1'b0;
      wb_data_reg   <= '0;
      wb_val_reg    <= 1'b0;
      wb_req_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wb_data_reg <= i_mem_data;
      wb_val_reg  <= accept_val;
      // Registered so a pe_ready drop in the grant cycle cannot truncate the request.
      wb_req_reg  <= (state_reg == ISSUE) && i_pe_ready;

      if (start_job) begin
        addr_reg     <= i_base_addr;
        set_cnt_reg  <= '0;
        num_wset_reg <= i_num_wset;
      end else if (rd_fire) begin
        addr_reg <= addr_reg + 1'b1;
      end

      if (state_reg != LOAD) begin
        rd_cnt_reg  <= '0;
        ret_cnt_reg <= '0;
      end else begin
        if (rd_fire)    rd_cnt_reg  <= rd_cnt_reg + 1'b1;
        if (accept_val) ret_cnt_reg <= ret_cnt_reg + 1'b1;
      end

      drain_cnt_reg <= (state_reg == DRAIN) ? ~drain_cnt_reg : 1'b0;
      if ((state_reg == DRAIN) && drain_cnt_reg) set_cnt_reg <= set_cnt_reg + 1'b1;
    end
  end

  assign o_mem_rd_en  = rd_fire;
  assign o_mem_addr   = addr_reg;
  assign o_wb_data_kn = wb_data_reg;
  assign o_wb_val     = wb_val_reg;
  assign o_wb_req     = wb_req_reg;
  assign o_busy       = (state_reg != IDLE);
  assign o_done       = (state_reg == DONE);

`ifdef WLC_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (start_job) begin
      stall_cnt_reg <= '0;
    end else if (((state_reg == WAIT_FULL) || ((state_reg == ISSUE) && !i_pe_ready))
                 && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_reg;
`else
  assign o_stall_cnt = 32'd0;
`endif

endmodule
